// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Purpose  : APB completer fronting a word-addressed memory. Every transfer
//            takes a fixed number of access-phase wait states. Addresses
//            outside [BASE_ADDR, BASE_ADDR+DEPTH) complete with PSLVERR=1
//            and never touch memory.
// Ports    : i_PCLK      - bus clock, rising edge
//            i_PRESETn   - asynchronous active-low reset
//            i_PADDR     - transfer address (sampled in the setup phase only)
//            i_PSEL      - slave select
//            i_PENABLE   - access-phase indicator
//            i_PWRITE    - 1 = write, 0 = read (sampled in setup only)
//            i_PWDATA    - write data (sampled in setup only)
//            o_PREADY    - registered completion, high for one cycle
//            o_PRDATA    - registered read data, valid while o_PREADY=1
//            o_PSLVERR   - registered error, valid while o_PREADY=1
// Config   : APB_SLAVE_MEM_WAIT_EN - when defined, WAIT_CYCLES wait states
//            are inserted. When undefined, the wait counter is removed and
//            every transfer is zero-wait.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic                  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic [DATA_WIDTH-1:0] o_PRDATA,
    output logic                  o_PSLVERR
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Range checks are done one bit wider than the address so that
    // PADDR - BASE_ADDR cannot wrap around.
    localparam logic [ADDR_WIDTH:0] c_BASE_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

`ifdef APB_SLAVE_MEM_WAIT_EN
    localparam logic [3:0] c_WAIT_EFF = 4'(WAIT_CYCLES);
`else
    // The parameter is accepted but has no effect in this build.
    localparam logic [3:0] c_WAIT_EFF = 4'(WAIT_CYCLES) & 4'h0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  r_state_q,   w_state_d;
    logic                    r_write_q,   w_write_d;
    logic                    r_err_q,     w_err_d;
    logic [c_IDX_W-1:0]      r_idx_q,     w_idx_d;
    logic [DATA_WIDTH-1:0]   r_wdata_q,   w_wdata_d;
    logic                    r_pready_q,  w_pready_d;
    logic                    r_pslverr_q, w_pslverr_d;
    logic [DATA_WIDTH-1:0]   r_prdata_q,  w_prdata_d;
`ifdef APB_SLAVE_MEM_WAIT_EN
    logic [3:0]              r_cnt_q,     w_cnt_d;
`endif

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_setup;
    logic [ADDR_WIDTH:0]     w_diff;
    logic                    w_err_new;
    logic [c_IDX_W-1:0]      w_idx_new;
    logic                    w_capture;
    logic                    w_complete;
    logic                    w_from_new;
    logic                    w_mem_we;
    logic                    w_sel_write;
    logic                    w_sel_err;
    logic [c_IDX_W-1:0]      w_sel_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_setup   = i_PSEL && !i_PENABLE;
    assign w_diff    = {1'b0, i_PADDR} - c_BASE_EXT;
    assign w_err_new = ({1'b0, i_PADDR} < c_BASE_EXT) || (w_diff >= c_DEPTH_EXT);
    assign w_idx_new = w_diff[c_IDX_W-1:0];

    always_comb begin
        w_state_d   = r_state_q;
        w_write_d   = r_write_q;
        w_err_d     = r_err_q;
        w_idx_d     = r_idx_q;
        w_wdata_d   = r_wdata_q;
        w_pready_d  = 1'b0;
        w_pslverr_d = 1'b0;
        w_prdata_d  = '0;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_from_new  = 1'b0;
        w_mem_we    = 1'b0;
        w_sel_write = r_write_q;
        w_sel_err   = r_err_q;
        w_sel_idx   = r_idx_q;
        w_rd_word   = '0;
`ifdef APB_SLAVE_MEM_WAIT_EN
        w_cnt_d     = r_cnt_q;
`endif

        case (r_state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    w_capture = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!(i_PSEL && i_PENABLE)) begin
                    w_state_d = ST_IDLE;
`ifdef APB_SLAVE_MEM_WAIT_EN
                    w_cnt_d   = 4'd0;
`endif
                end else begin
`ifdef APB_SLAVE_MEM_WAIT_EN
                    // The counter was loaded with the wait count at setup;
                    // completing when it reaches 1 places PREADY in
                    // access cycle 1+WAIT_CYCLES.
                    if (r_cnt_q <= 4'd1) begin
                        w_complete = 1'b1;
                        w_state_d  = ST_DONE;
                        w_cnt_d    = 4'd0;
                    end else begin
                        w_cnt_d    = r_cnt_q - 4'd1;
                    end
`else
                    w_complete = 1'b1;
                    w_state_d  = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (!i_PSEL) begin
                    // Abort: the pending write is dropped.
                    w_state_d = ST_IDLE;
                end else begin
                    w_mem_we = r_write_q && !r_err_q;
                    if (w_setup) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_capture) begin
            w_write_d = i_PWRITE;
            w_err_d   = w_err_new;
            w_idx_d   = w_idx_new;
            w_wdata_d = i_PWDATA;
            if (c_WAIT_EFF == 4'd0) begin
                // Zero-wait: PREADY must already be high in the first
                // access cycle, so complete straight from setup.
                w_complete = 1'b1;
                w_from_new = 1'b1;
                w_state_d  = ST_DONE;
            end else begin
`ifdef APB_SLAVE_MEM_WAIT_EN
                w_cnt_d    = c_WAIT_EFF;
`endif
                w_state_d  = ST_ACCESS;
            end
        end

        if (w_from_new) begin
            w_sel_write = i_PWRITE;
            w_sel_err   = w_err_new;
            w_sel_idx   = w_idx_new;
        end

        // A write committing on this same edge must be visible to a read
        // completing on it (back-to-back read-after-write, zero-wait).
        w_rd_word = r_mem[w_sel_idx];
        if (w_mem_we && (r_idx_q == w_sel_idx)) begin
            w_rd_word = r_wdata_q;
        end

        if (w_complete) begin
            w_pready_d  = 1'b1;
            w_pslverr_d = w_sel_err;
            if (!w_sel_write && !w_sel_err) begin
                w_prdata_d = w_rd_word;
            end
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            r_state_q   <= ST_IDLE;
            r_write_q   <= 1'b0;
            r_err_q     <= 1'b0;
            r_idx_q     <= '0;
            r_wdata_q   <= '0;
            r_pready_q  <= 1'b0;
            r_pslverr_q <= 1'b0;
            r_prdata_q  <= '0;
`ifdef APB_SLAVE_MEM_WAIT_EN
            r_cnt_q     <= 4'd0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_write_q   <= w_write_d;
            r_err_q     <= w_err_d;
            r_idx_q     <= w_idx_d;
            r_wdata_q   <= w_wdata_d;
            r_pready_q  <= w_pready_d;
            r_pslverr_q <= w_pslverr_d;
            r_prdata_q  <= w_prdata_d;
`ifdef APB_SLAVE_MEM_WAIT_EN
            r_cnt_q     <= w_cnt_d;
`endif
        end
    end

    // Memory contents are intentionally not reset.
    always_ff @(posedge i_PCLK) begin
        if (w_mem_we) begin
            r_mem[r_idx_q] <= r_wdata_q;
        end
    end

    assign o_PREADY  = r_pready_q;
    assign o_PRDATA  = r_prdata_q;
    assign o_PSLVERR = r_pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_mem
// Purpose  : Self-checking bench for apb_slave_mem (BASE_ADDR=0x0100,
//            DEPTH=256, WAIT_CYCLES=2). Directed scenarios followed by
//            randomized transfers against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int BASE  = 16'h0100;
    localparam int WAIT  = 2;
`ifdef APB_SLAVE_MEM_WAIT_EN
    localparam int W_EFF = WAIT;
`else
    localparam int W_EFF = 0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [DEPTH];
    int            cur_a;
    logic          cur_w;
    logic [DW-1:0] cur_d;

    apb_slave_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .i_PCLK   (pclk),
        .i_PRESETn(presetn),
        .i_PADDR  (paddr),
        .i_PSEL   (psel),
        .i_PENABLE(penable),
        .i_PWRITE (pwrite),
        .i_PWDATA (pwdata),
        .o_PREADY (pready),
        .o_PRDATA (prdata),
        .o_PSLVERR(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input int a);
        return (a >= BASE) && (a - BASE < DEPTH);
    endfunction

    // Drive a setup phase in the current cycle.
    task automatic start_setup(input int a, input logic w, input logic [DW-1:0] d);
        cur_a   = a;
        cur_w   = w;
        cur_d   = d;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = AW'(a);
        pwrite  = w;
        pwdata  = d;
    endtask

    // Run the access phase; returns inside the PREADY cycle with PSEL/PENABLE high.
    task automatic finish();
        logic          err_e;
        logic [DW-1:0] rd_e;
        err_e = !in_range(cur_a);
        rd_e  = (!cur_w && !err_e) ? mdl[cur_a - BASE] : '0;
        for (int k = 1; k <= W_EFF + 1; k++) begin
            @(posedge pclk); #1;
            if (k == 1) begin
                penable = 1'b1;
                // Address/data changes during access must be ignored.
                paddr   = AW'($urandom);
                pwdata  = DW'($urandom);
                pwrite  = 1'($urandom_range(0, 1));
            end
            chk("pready_timing", 32'(pready), 32'(k == W_EFF + 1));
        end
        chk("pslverr", 32'(pslverr), 32'(err_e));
        chk("prdata", 32'(prdata), 32'(rd_e));
        if (cur_w && !err_e) mdl[cur_a - BASE] = cur_d;
    endtask

    // Leave the PREADY cycle and return the bus to idle.
    task automatic step();
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        chk("pready_drop", 32'(pready), 32'd0);
        chk("prdata_drop", 32'(prdata), 32'd0);
    endtask

    task automatic xfer(input int a, input logic w, input logic [DW-1:0] d);
        start_setup(a, w, d);
        finish();
        step();
    endtask

    initial begin
        // Reset with all inputs low.
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", 32'(prdata), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) xfer(BASE + i, 1'b1, DW'($urandom));

        // Write then read back.
        xfer(BASE + 16'h0010, 1'b1, 16'hBEEF);
        xfer(BASE + 16'h0010, 1'b0, 16'h0000);

        // Out-of-range read below base and write above top; then confirm
        // the base word was not disturbed.
        xfer(16'h00FF, 1'b0, 16'h0000);
        xfer(16'h0200, 1'b1, 16'h5555);
        xfer(16'h0100, 1'b0, 16'h0000);

        // Back-to-back write then read of the same word, no idle cycle.
        start_setup(16'h0101, 1'b1, 16'h1234);
        finish();
        start_setup(16'h0101, 1'b0, 16'h0000);
        finish();
        step();
        chk("b2b_model", 32'(mdl[1]), 32'h1234);

        // Abort: PSEL drops in the first access cycle of a write.
        start_setup(16'h0103, 1'b1, 16'hAAAA);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        if (W_EFF > 0) chk("abort_pready_a1", 32'(pready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            chk("abort_pready_after", 32'(pready), 32'd0);
        end
        xfer(16'h0103, 1'b0, 16'h0000);

        // Reset asserted in the first access cycle of a write.
        start_setup(16'h0105, 1'b1, 16'h5A5A);
        @(posedge pclk); #1;
        penable = 1'b1;
        presetn = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready), 32'd0);
        chk("midrst_prdata", 32'(prdata), 32'd0);
        chk("midrst_pslverr", 32'(pslverr), 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(16'h0105, 1'b0, 16'h0000);

        // Randomized traffic spanning both sides of the decoded window,
        // with random back-to-back chaining.
        for (int n = 0; n < 120; n++) begin
            start_setup(16'h00F0 + int'($urandom_range(0, 16'h0130)),
                        1'($urandom_range(0, 1)), DW'($urandom));
            finish();
            if ($urandom_range(0, 1) == 0 || n == 119) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
